sdes_iter_core: RTL and testbench

- Iterative, handshaked S-DES engine: one Feistel round per clock; encrypt or decrypt; ECB or CBC chaining.
- Parametrised successor of the combinational board-level S-DES datapath: round count configurable, key schedule generated internally, chaining state held across blocks.
- Sits between the 1 Hz test counter / switch inputs and the 7-seg display path. Also usable as a stream cipher block behind any valid/ready source.

---
 rtl/sdes_pkg.sv | 105 ++++++++++
 rtl/sdes_round.sv | 31 +++
 rtl/sdes_iter_core.sv | 153 +++++++++++++++
 tb/tb_sdes_iter_core.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdes_pkg.sv
// sdes_pkg: shared S-DES definitions.
//   - block/key typedefs and the FSM state enum
//   - permutation index tables (bit 1 = MSB) and the S-box tables
//   - permutation helpers, S-box lookups, the key-half rotation and the
//     per-round rotation amount
package sdes_pkg;

  typedef logic [7:0] block_t;
  typedef logic [9:0] key_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Output position j (MSB first) takes input bit IDX[j] (1 = MSB).
  localparam int P10_IDX [10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
  localparam int P8_IDX  [8]  = '{6, 3, 7, 4, 8, 5, 10, 9};
  localparam int IP_IDX  [8]  = '{2, 6, 3, 1, 4, 8, 5, 7};
  localparam int IPI_IDX [8]  = '{4, 1, 3, 5, 7, 2, 8, 6};
  localparam int EP_IDX  [8]  = '{4, 1, 2, 3, 2, 3, 4, 1};
  localparam int P4_IDX  [4]  = '{2, 4, 3, 1};

  localparam logic [1:0] S0_TAB [4][4] = '{'{2'd1, 2'd0, 2'd3, 2'd2},
                                           '{2'd3, 2'd2, 2'd1, 2'd0},
                                           '{2'd0, 2'd2, 2'd1, 2'd3},
                                           '{2'd3, 2'd1, 2'd3, 2'd2}};
  localparam logic [1:0] S1_TAB [4][4] = '{'{2'd0, 2'd1, 2'd2, 2'd3},
                                           '{2'd2, 2'd0, 2'd1, 2'd3},
                                           '{2'd3, 2'd0, 2'd1, 2'd0},
                                           '{2'd2, 2'd1, 2'd0, 2'd3}};

  function automatic key_t perm_p10(input key_t v);
    key_t r;
    r = 10'd0;
    for (int j = 0; j < 10; j++) r[9-j] = v[10-P10_IDX[j]];
    return r;
  endfunction

  function automatic block_t perm_p8(input key_t v);
    block_t r;
    r = 8'd0;
    for (int j = 0; j < 8; j++) r[7-j] = v[10-P8_IDX[j]];
    return r;
  endfunction

  function automatic block_t perm_ip(input block_t v);
    block_t r;
    r = 8'd0;
    for (int j = 0; j < 8; j++) r[7-j] = v[8-IP_IDX[j]];
    return r;
  endfunction

  function automatic block_t perm_ip_inv(input block_t v);
    block_t r;
    r = 8'd0;
    for (int j = 0; j < 8; j++) r[7-j] = v[8-IPI_IDX[j]];
    return r;
  endfunction

  function automatic block_t perm_ep(input logic [3:0] v);
    block_t r;
    r = 8'd0;
    for (int j = 0; j < 8; j++) r[7-j] = v[4-EP_IDX[j]];
    return r;
  endfunction

  function automatic logic [3:0] perm_p4(input logic [3:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int j = 0; j < 4; j++) r[3-j] = v[4-P4_IDX[j]];
    return r;
  endfunction

  // Row = bits 1,4 ; column = bits 2,3 of the 4-bit S-box input.
  function automatic logic [1:0] sbox0(input logic [3:0] x);
    return S0_TAB[{x[3], x[0]}][{x[2], x[1]}];
  endfunction

  function automatic logic [1:0] sbox1(input logic [3:0] x);
    return S1_TAB[{x[3], x[0]}][{x[2], x[1]}];
  endfunction

  function automatic logic [4:0] rotl5(input logic [4:0] v, input logic [2:0] n);
    logic [4:0] r;
    case (n)
      3'd0:    r = v;
      3'd1:    r = {v[3:0], v[4]};
      3'd2:    r = {v[2:0], v[4:3]};
      3'd3:    r = {v[1:0], v[4:2]};
      3'd4:    r = {v[0], v[4:1]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Cumulative rotation for round r: (1 + 2r) mod 5.
  function automatic logic [2:0] rot_amount(input logic [3:0] r);
    logic [5:0] m;
    m = (6'd1 + {1'b0, r, 1'b0}) % 6'd5;
    return m[2:0];
  endfunction

endpackage

// File: rtl/sdes_round.sv
// sdes_round: one combinational Feistel round.
//   blk  - current (L,R) state, L in [7:4]
//   rkey - 8-bit round key
//   swap - exchange halves after the round (all rounds but the last)
//   res  - next state
module sdes_round
  import sdes_pkg::*;
(
  input  logic [7:0] blk,
  input  logic [7:0] rkey,
  input  logic       swap,
  output logic [7:0] res
);

  logic [7:0] ep_x_s;
  logic [3:0] f_out_s;
  logic [3:0] l_new_s;

  // F-function on R, mixed into L, then optional half swap
  always_comb begin
    ep_x_s  = perm_ep(blk[3:0]) ^ rkey;
    f_out_s = perm_p4({sbox0(ep_x_s[7:4]), sbox1(ep_x_s[3:0])});
    l_new_s = blk[7:4] ^ f_out_s;
    if (swap) begin
      res = {blk[3:0], l_new_s};
    end else begin
      res = {l_new_s, blk[3:0]};
    end
  end

endmodule

// File: rtl/sdes_iter_core.sv
// sdes_iter_core: iterative handshaked S-DES engine, one round per clock.
//   CLOCK_50            clock; rst synchronous active-high
//   in_valid/in_ready   input handshake for in_data, in_key, in_decrypt, in_cbc
//   iv_load/iv_data     chaining register load, honoured only in IDLE
//   out_valid/out_ready output handshake for out_data
//   busy                high while a block is in RUN or DONE
// NUM_ROUNDS legal range 2..16; CBC_EN=0 forces ECB.
module sdes_iter_core
  import sdes_pkg::*;
#(
  parameter int NUM_ROUNDS = 2,
  parameter bit CBC_EN     = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic [9:0] in_key,
  input  logic       in_decrypt,
  input  logic       in_cbc,
  input  logic       iv_load,
  input  logic [7:0] iv_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS - 1);

  state_t     state_r;
  block_t     blk_r;
  key_t       key_r;
  block_t     ct_r;
  block_t     chain_r;
  logic       dec_r;
  logic       cbc_r;
  logic [3:0] rnd_r;

  logic [3:0] ridx_s;
  logic [2:0] rot_s;
  key_t       kp_s;
  block_t     rkey_s;
  logic       last_s;
  block_t     iv_eff_s;
  block_t     pre_s;
  block_t     round_out_s;
  block_t     res_s;
  block_t     final_s;

  // Round key selection, load-side pre-whitening and output post-processing
  always_comb begin
    if (dec_r) begin
      ridx_s = LAST_RND - rnd_r;
    end else begin
      ridx_s = rnd_r;
    end
    rot_s  = rot_amount(ridx_s);
    kp_s   = perm_p10(key_r);
    rkey_s = perm_p8({rotl5(kp_s[9:5], rot_s), rotl5(kp_s[4:0], rot_s)});
    last_s = (rnd_r == LAST_RND);
    // A same-cycle iv_load supplies the IV for the block being accepted.
    if ((CBC_EN == 1'b1) && iv_load) begin
      iv_eff_s = iv_data;
    end else begin
      iv_eff_s = chain_r;
    end
    if ((CBC_EN == 1'b1) && in_cbc && !in_decrypt) begin
      pre_s = in_data ^ iv_eff_s;
    end else begin
      pre_s = in_data;
    end
    res_s = perm_ip_inv(round_out_s);
    if (cbc_r && dec_r) begin
      final_s = res_s ^ chain_r;
    end else begin
      final_s = res_s;
    end
  end

  sdes_round u_round (
    .blk  (blk_r),
    .rkey (rkey_s),
    .swap (!last_s),
    .res  (round_out_s)
  );

  // Control FSM, datapath registers, chaining register and registered outputs
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 8'd0;
      busy      <= 1'b0;
      chain_r   <= 8'd0;
      blk_r     <= 8'd0;
      key_r     <= 10'd0;
      ct_r      <= 8'd0;
      dec_r     <= 1'b0;
      cbc_r     <= 1'b0;
      rnd_r     <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if ((CBC_EN == 1'b1) && iv_load) begin
            chain_r <= iv_data;
          end
          if (in_valid) begin
            blk_r    <= perm_ip(pre_s);
            key_r    <= in_key;
            ct_r     <= in_data;
            dec_r    <= in_decrypt;
            cbc_r    <= (CBC_EN == 1'b1) && in_cbc;
            rnd_r    <= 4'd0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state_r  <= ST_RUN;
          end
        end
        ST_RUN: begin
          blk_r <= round_out_s;
          rnd_r <= rnd_r + 4'd1;
          if (last_s) begin
            out_data  <= final_s;
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state_r   <= ST_IDLE;
            // Encrypt chains on its own ciphertext, decrypt on the input ciphertext.
            if (cbc_r) begin
              chain_r <= dec_r ? ct_r : out_data;
            end
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdes_iter_core.sv
// tb_sdes_iter_core: directed self-checking bench for sdes_iter_core.
// Two instances: dut (2 rounds, CBC) and dut4 (4 rounds, ECB only).
`timescale 1ns/1ps
module tb_sdes_iter_core;

  localparam logic [9:0] KEY_STD = 10'b1010000010;
  localparam logic [9:0] KEY_B   = 10'h2A5;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid4, out_ready, out_ready4;
  logic [7:0] in_data, iv_data;
  logic [9:0] in_key;
  logic       in_decrypt, in_cbc, iv_load;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_data;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_data4;

  int errors = 0;
  int checks = 0;

  // 100 MHz bench clock
  always #5 clk = ~clk;

  sdes_iter_core #(.NUM_ROUNDS(2), .CBC_EN(1'b1)) dut (
    .CLOCK_50(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt), .in_cbc(in_cbc),
    .iv_load(iv_load), .iv_data(iv_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  sdes_iter_core #(.NUM_ROUNDS(4), .CBC_EN(1'b0)) dut4 (
    .CLOCK_50(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_data(in_data), .in_key(in_key), .in_decrypt(in_decrypt), .in_cbc(in_cbc),
    .iv_load(iv_load), .iv_data(iv_data), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_data(out_data4), .busy(busy4)
  );

  // One block through the selected core. lat counts cycles from the
  // handshake cycle (cycle 0) to the first cycle with out_valid high.
  // With disturb set, inputs are scrambled while the block is in flight.
  task automatic xfer(input bit u4, input logic [7:0] d, input logic [9:0] k,
                      input logic dec, input logic cbc, input logic ivl,
                      input logic [7:0] ivd, input bit disturb,
                      output logic [7:0] res, output int lat);
    int n;
    in_data = d; in_key = k; in_decrypt = dec; in_cbc = cbc;
    iv_load = ivl; iv_data = ivd;
    if (u4) in_valid4 = 1'b1; else in_valid = 1'b1;
    n = 0;
    while (((u4 ? in_ready4 : in_ready) !== 1'b1) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid4 = 1'b0; iv_load = 1'b0;
    if (disturb) begin
      in_data = ~d; in_key = ~k; in_decrypt = ~dec; in_cbc = ~cbc;
      iv_load = 1'b1; iv_data = 8'hFF;
    end
    lat = 1;
    while (((u4 ? out_valid4 : out_valid) !== 1'b1) && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    checks++;
    if ((u4 ? out_valid4 : out_valid) !== 1'b1) begin
      errors++;
      $display("FAIL xfer_timeout: out_valid=%b required 1", (u4 ? out_valid4 : out_valid));
    end
    res = u4 ? out_data4 : out_data;
    if (u4) out_ready4 = 1'b1; else out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; out_ready4 = 1'b0; iv_load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    in_data = 8'h00; in_key = 10'h000; in_decrypt = 1'b0; in_cbc = 1'b0;
    iv_load = 1'b0; iv_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data: got %h want 00", out_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (in_ready4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready4: got %b want 1", in_ready4); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_std_vectors();
    logic [7:0] r;
    int lat;
    xfer(1'b0, 8'h97, KEY_STD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h38) begin errors++; $display("FAIL std_enc: got %h want 38", r); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL std_latency: got %0d want 3", lat); end
    xfer(1'b0, 8'h38, KEY_STD, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h97) begin errors++; $display("FAIL std_dec: got %h want 97", r); end
    xfer(1'b0, 8'h00, KEY_B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'hE0) begin errors++; $display("FAIL keyb_enc00: got %h want e0", r); end
    xfer(1'b0, 8'hFF, KEY_B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h73) begin errors++; $display("FAIL keyb_encff: got %h want 73", r); end
    xfer(1'b0, 8'hE0, KEY_B, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL keyb_dece0: got %h want 00", r); end
    xfer(1'b0, 8'h73, KEY_B, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'hFF) begin errors++; $display("FAIL keyb_dec73: got %h want ff", r); end
  endtask

  task automatic test_roundtrip(input bit u4);
    logic [7:0] c, p;
    int lat;
    for (int i = 0; i < 256; i++) begin
      xfer(u4, 8'(i), KEY_B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, c, lat);
      xfer(u4, c, KEY_B, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, p, lat);
      checks++;
      if (p !== 8'(i)) begin errors++; $display("FAIL roundtrip r4=%0d: block %h gave %h want %h", u4, 8'(i), p, 8'(i)); end
    end
  endtask

  task automatic test_cbc_chain();
    logic [7:0] r;
    int lat;
    // IV 0x97 loaded with the handshake: 0x00^0x97 encrypts to 0x38.
    xfer(1'b0, 8'h00, KEY_STD, 1'b0, 1'b1, 1'b1, 8'h97, 1'b1, r, lat);
    checks++; if (r !== 8'h38) begin errors++; $display("FAIL cbc_enc1: got %h want 38", r); end
    // Chain is now 0x38: 0xAF^0x38 = 0x97 -> 0x38.
    xfer(1'b0, 8'hAF, KEY_STD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, r, lat);
    checks++; if (r !== 8'h38) begin errors++; $display("FAIL cbc_enc2: got %h want 38", r); end
    xfer(1'b0, 8'h38, KEY_STD, 1'b1, 1'b1, 1'b1, 8'h97, 1'b1, r, lat);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL cbc_dec1: got %h want 00", r); end
    xfer(1'b0, 8'h38, KEY_STD, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, r, lat);
    checks++; if (r !== 8'hAF) begin errors++; $display("FAIL cbc_dec2: got %h want af", r); end
  endtask

  task automatic test_cbc_iv55();
    logic [7:0] c1, c2, p;
    int lat;
    iv_load = 1'b1; iv_data = 8'h55;
    @(posedge clk); #1; iv_load = 1'b0;
    xfer(1'b0, 8'h00, KEY_STD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, c1, lat);
    xfer(1'b0, 8'h00, KEY_STD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, c2, lat);
    checks++; if (c1 === c2) begin errors++; $display("FAIL cbc_iv55_differ: c1=%h c2=%h want different", c1, c2); end
    iv_load = 1'b1; iv_data = 8'h55;
    @(posedge clk); #1; iv_load = 1'b0;
    xfer(1'b0, c1, KEY_STD, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, p, lat);
    checks++; if (p !== 8'h00) begin errors++; $display("FAIL cbc_iv55_dec1: got %h want 00", p); end
    xfer(1'b0, c2, KEY_STD, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, p, lat);
    checks++; if (p !== 8'h00) begin errors++; $display("FAIL cbc_iv55_dec2: got %h want 00", p); end
  endtask

  task automatic test_backpressure();
    int n;
    in_data = 8'h97; in_key = KEY_STD; in_decrypt = 1'b0; in_cbc = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid c%0d: got %b want 1", c, out_valid); end
      checks++; if (out_data !== 8'h38) begin errors++; $display("FAIL bp_hold_data c%0d: got %h want 38", c, out_data); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready c%0d: got %b want 0", c, in_ready); end
    end
    out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_release_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_single_xfer: got %b want 0", out_valid); end
  endtask

  task automatic test_reset_in_run();
    logic [7:0] r;
    int lat;
    bit seen;
    in_data = 8'h11; in_key = KEY_STD; in_decrypt = 1'b0; in_cbc = 1'b1;
    iv_load = 1'b1; iv_data = 8'h55; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; iv_load = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstrun_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstrun_in_ready: got %b want 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstrun_busy: got %b want 0", busy); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    out_ready = 1'b0;
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstrun_no_output: got %b want 0", seen); end
    // ECB leaves the cleared chain alone; CBC 0x97 on chain 0 gives 0x38.
    xfer(1'b0, 8'h00, KEY_STD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    xfer(1'b0, 8'h97, KEY_STD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h38) begin errors++; $display("FAIL rstrun_chain_zero: got %h want 38", r); end
    xfer(1'b0, 8'h00, KEY_STD, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    xfer(1'b0, 8'hAF, KEY_STD, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h38) begin errors++; $display("FAIL ecb_keeps_chain: got %h want 38", r); end
  endtask

  task automatic test_rounds4();
    logic [7:0] r;
    int lat;
    xfer(1'b1, 8'h00, KEY_B, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'hAD) begin errors++; $display("FAIL r4_enc00: got %h want ad", r); end
    checks++; if (lat !== 5) begin errors++; $display("FAIL r4_latency: got %0d want 5", lat); end
    xfer(1'b1, 8'hAD, KEY_B, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, r, lat);
    checks++; if (r !== 8'h00) begin errors++; $display("FAIL r4_decad: got %h want 00", r); end
    test_roundtrip(1'b1);
  endtask

  task automatic test_back_to_back();
    int first, second, ov_cnt;
    bit bad_data;
    first = -1; second = -1; ov_cnt = 0; bad_data = 1'b0;
    in_data = 8'h97; in_key = KEY_STD; in_decrypt = 1'b0; in_cbc = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready === 1'b1 && second < 0) begin
        if (first < 0) first = c; else second = c;
      end
      if (out_valid === 1'b1) begin
        ov_cnt++;
        if (out_data !== 8'h38) bad_data = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1; out_ready = 1'b0;
    checks++; if ((second - first) !== 4) begin errors++; $display("FAIL b2b_spacing: got %0d want 4", second - first); end
    checks++; if (ov_cnt !== 5) begin errors++; $display("FAIL b2b_out_count: got %0d want 5", ov_cnt); end
    checks++; if (bad_data !== 1'b0) begin errors++; $display("FAIL b2b_data: bad=%b want 0", bad_data); end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_std_vectors();
    test_roundtrip(1'b0);
    test_cbc_chain();
    test_cbc_iv55();
    test_backpressure();
    test_reset_in_run();
    test_rounds4();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
